threadkraken_mmu: RTL and testbench

Memory-side responder for the ThreadKraken core's instruction and data ports. Translates per-thread virtual addresses through an 8-entry segment table (base/limit), checks bounds and alignment, and serves accesses from single-word I and D fill buffers. Misses are refilled from a single-ported, variable-latency backing-memory port through a small FSM. The core replays any access that returned `miss`.

---
 rtl/threadkraken_mmu.sv | 166 ++++++++++++++++
 tb/tb_threadkraken_mmu.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threadkraken_mmu.sv
`default_nettype none
// ============================================================================
// Module   : threadkraken_mmu
// Purpose  : Segment-translating I/D responder with single-word fill buffers
//            and a refill/write-through FSM on one backing-memory port.
// Revision : 1.0 - initial release
// ============================================================================
module threadkraken_mmu #(
  parameter logic [31:0] RESET_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic [2:0]  i_trd,
  output logic [31:0] i_rd_data,
  output logic        i_miss,
  output logic        i_segfault,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wr_data,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [2:0]  d_trd,
  output logic [31:0] d_rd_data,
  output logic        d_miss,
  output logic        d_segfault,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_trd,
  input  logic        cfg_lim,
  input  logic [31:0] cfg_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL_I = 2'd1,
    S_FILL_D = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_base  [8];
  logic [31:0] r_limit [8];
  logic        r_ib_valid;
  logic [31:0] r_ib_tag;
  logic [31:0] r_ib_data;
  logic        r_db_valid;
  logic [31:0] r_db_tag;
  logic [31:0] r_db_data;

  logic [31:0] w_i_pa;
  logic [31:0] w_d_pa;
  logic        w_i_fault;
  logic        w_i_hit;
  logic        w_i_need;
  logic        w_d_fault;
  logic        w_d_store;
  logic        w_d_load;
  logic        w_d_hit;
  logic        w_d_need;
  logic        w_idle;
  logic        w_d_start;
  logic        w_i_start;

  assign w_i_pa    = r_base[i_trd] + i_addr;
  assign w_d_pa    = r_base[d_trd] + d_addr;
  assign w_i_fault = i_rd && ((i_addr >= r_limit[i_trd]) || (i_addr[1:0] != 2'b00));
  assign w_i_hit   = i_rd && !w_i_fault && r_ib_valid && (r_ib_tag == w_i_pa);
  assign w_i_need  = i_rd && !w_i_fault && !w_i_hit;
  assign w_d_fault = (d_rd || d_wr) &&
                     ((d_addr >= r_limit[d_trd]) || (d_addr[1:0] != 2'b00));
  assign w_d_store = d_wr && !w_d_fault;
  assign w_d_load  = d_rd && !d_wr && !w_d_fault;
  assign w_d_hit   = w_d_load && r_db_valid && (r_db_tag == w_d_pa);
  assign w_d_need  = w_d_load && !w_d_hit;
  assign w_idle    = (r_state == S_IDLE);
  // Data side owns the port whenever it wants it; the fetch simply replays.
  assign w_d_start = w_idle && (w_d_store || w_d_need);
  assign w_i_start = w_idle && !w_d_start && w_i_need;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        r_base[k]  <= 32'h0;
        r_limit[k] <= (k == 0) ? RESET_LIMIT : 32'h0;
      end
    end else if (cfg_we) begin
      if (cfg_lim) r_limit[cfg_trd] <= cfg_wdata;
      else         r_base[cfg_trd]  <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ib_valid <= 1'b0;
      r_ib_tag   <= 32'h0;
      r_ib_data  <= 32'h0;
      r_db_valid <= 1'b0;
      r_db_tag   <= 32'h0;
      r_db_data  <= 32'h0;
      i_rd_data  <= 32'h0;
      i_miss     <= 1'b0;
      i_segfault <= 1'b0;
      d_rd_data  <= 32'h0;
      d_miss     <= 1'b0;
      d_segfault <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      i_rd_data  <= w_i_hit ? r_ib_data : 32'h0;
      i_miss     <= w_i_need;
      i_segfault <= w_i_fault;
      d_rd_data  <= w_d_hit ? r_db_data : 32'h0;
      d_miss     <= w_d_need || (w_d_store && !w_idle);
      d_segfault <= w_d_fault;

      case (r_state)
        S_IDLE: begin
          if (w_d_start) begin
            r_state   <= w_d_store ? S_WRITE : S_FILL_D;
            mem_req   <= 1'b1;
            mem_we    <= w_d_store;
            mem_addr  <= w_d_pa;
            mem_wdata <= w_d_store ? d_wr_data : 32'h0;
            // Keep both buffers coherent with the write-through.
            if (w_d_store && (r_ib_tag == w_d_pa)) r_ib_data <= d_wr_data;
            if (w_d_store && (r_db_tag == w_d_pa)) r_db_data <= d_wr_data;
          end else if (w_i_start) begin
            r_state   <= S_FILL_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= w_i_pa;
            mem_wdata <= 32'h0;
          end
        end
        default: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (r_state == S_FILL_I) begin
              r_ib_valid <= 1'b1;
              r_ib_tag   <= mem_addr;
              r_ib_data  <= mem_rdata;
            end
            if (r_state == S_FILL_D) begin
              r_db_valid <= 1'b1;
              r_db_tag   <= mem_addr;
              r_db_data  <= mem_rdata;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_threadkraken_mmu.sv
`default_nettype none
// ============================================================================
// Module   : tb_threadkraken_mmu
// Purpose  : Directed vector table plus multi-cycle sequences for the MMU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_threadkraken_mmu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_rd;
  logic [2:0]  i_trd;
  logic [31:0] i_rd_data;
  logic        i_miss;
  logic        i_segfault;
  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic        d_rd;
  logic        d_wr;
  logic [2:0]  d_trd;
  logic [31:0] d_rd_data;
  logic        d_miss;
  logic        d_segfault;
  logic        cfg_we;
  logic [2:0]  cfg_trd;
  logic        cfg_lim;
  logic [31:0] cfg_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int          checks = 0;
  int          errors = 0;
  int          lat = 3;
  int          wr_cnt = 0;
  logic [31:0] mem [1024];

  threadkraken_mmu #(.RESET_LIMIT(32'h0001_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
    .i_rd_data(i_rd_data), .i_miss(i_miss), .i_segfault(i_segfault),
    .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
    .d_rd_data(d_rd_data), .d_miss(d_miss), .d_segfault(d_segfault),
    .cfg_we(cfg_we), .cfg_trd(cfg_trd), .cfg_lim(cfg_lim), .cfg_wdata(cfg_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Backing memory: acks after lat+1 observed request cycles, drops on reset.
  initial begin
    int cnt;
    logic [9:0] idx;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE_0000 | 32'(k);
    mem[8] = 32'h0000_AAAA;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt >= lat) begin
          idx = mem_addr[11:2];
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[idx] = mem_wdata;
            wr_cnt++;
          end else begin
            mem_rdata = mem[idx];
          end
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  typedef struct {
    logic        i_rd;
    logic [31:0] i_addr;
    logic [2:0]  i_trd;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [2:0]  d_trd;
    logic [31:0] e_i_data;
    logic        e_i_miss;
    logic        e_i_seg;
    logic        e_d_miss;
    logic        e_d_seg;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clear_in();
    i_rd = 1'b0; i_addr = 32'h0; i_trd = 3'd0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 32'h0; d_trd = 3'd0; d_wr_data = 32'h0;
    cfg_we = 1'b0; cfg_trd = 3'd0; cfg_lim = 1'b0; cfg_wdata = 32'h0;
  endtask

  // Returns in the cycle after the ack, when the FSM is idle again.
  task automatic wait_done(input string name, input logic [31:0] exp_addr, input logic exp_we);
    int n;
    n = 0;
    while (mem_ack !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 100 cycles", name);
    end
    chk({name, "_ack_addr"}, mem_addr, exp_addr);
    chk1({name, "_ack_we"}, mem_we, exp_we);
    tick();
    chk1({name, "_req_drop"}, mem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wc0;
    int n;
    clear_in();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_i_data", i_rd_data, 32'h0);
    chk1("rst_i_miss", i_miss, 1'b0);
    chk1("rst_i_seg", i_segfault, 1'b0);
    chk1("rst_d_miss", d_miss, 1'b0);
    chk1("rst_d_seg", d_segfault, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);

    // First fetch refills through the port with latency 3.
    lat = 3;
    i_rd = 1'b1; i_addr = 32'h10; i_trd = 3'd0;
    tick();
    clear_in();
    chk1("a_i_miss", i_miss, 1'b1);
    chk("a_i_data", i_rd_data, 32'h0);
    chk1("a_req", mem_req, 1'b1);
    chk("a_addr", mem_addr, 32'h10);
    chk1("a_we", mem_we, 1'b0);
    wait_done("a", 32'h10, 1'b0);
    i_rd = 1'b1; i_addr = 32'h10;
    tick();
    clear_in();
    chk("a_replay_data", i_rd_data, 32'hC0DE_0004);
    chk1("a_replay_miss", i_miss, 1'b0);

    // Single-cycle vectors: faults, a hit and the idle case.
    vt[0] = '{1'b1, 32'h0001_0000, 3'd0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h2, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 32'h0, 3'd3, 1'b1, 1'b0, 32'h0, 3'd3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 32'h10, 3'd0, 1'b0, 1'b0, 32'h0, 3'd0, 32'hC0DE_0004, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 32'h12, 3'd0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 32'h10, 3'd0, 1'b0, 1'b0, 32'h10, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h4, 3'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 32'hFFFF_FFFC, 3'd0, 1'b1, 1'b0, 32'h0000_FFFE, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int v = 0; v < 8; v++) begin
      i_rd = vt[v].i_rd; i_addr = vt[v].i_addr; i_trd = vt[v].i_trd;
      d_rd = vt[v].d_rd; d_wr = vt[v].d_wr; d_addr = vt[v].d_addr; d_trd = vt[v].d_trd;
      d_wr_data = 32'h0BAD_0BAD;
      tick();
      clear_in();
      chk($sformatf("v%0d_i_data", v), i_rd_data, vt[v].e_i_data);
      chk1($sformatf("v%0d_i_miss", v), i_miss, vt[v].e_i_miss);
      chk1($sformatf("v%0d_i_seg", v), i_segfault, vt[v].e_i_seg);
      chk1($sformatf("v%0d_d_miss", v), d_miss, vt[v].e_d_miss);
      chk1($sformatf("v%0d_d_seg", v), d_segfault, vt[v].e_d_seg);
      chk("v_d_data", d_rd_data, 32'h0);
      chk1($sformatf("v%0d_no_req", v), mem_req, 1'b0);
    end

    // Thread 2 segment; a same-cycle cfg write is not yet visible.
    cfg_we = 1'b1; cfg_trd = 3'd2; cfg_lim = 1'b0; cfg_wdata = 32'h8000;
    tick();
    cfg_lim = 1'b1; cfg_wdata = 32'h100;
    tick();
    cfg_trd = 3'd3; cfg_lim = 1'b1; cfg_wdata = 32'h100;
    d_rd = 1'b1; d_addr = 32'h0; d_trd = 3'd3;
    tick();
    clear_in();
    chk1("cfg_old_limit_seg", d_segfault, 1'b1);
    d_rd = 1'b1; d_addr = 32'h100; d_trd = 3'd2;
    tick();
    clear_in();
    chk1("t2_limit_seg", d_segfault, 1'b1);
    chk1("t2_limit_no_req", mem_req, 1'b0);
    d_rd = 1'b1; d_addr = 32'h40; d_trd = 3'd2;
    tick();
    clear_in();
    chk1("t2_d_miss", d_miss, 1'b1);
    chk("t2_addr", mem_addr, 32'h8040);
    wait_done("t2", 32'h8040, 1'b0);
    d_rd = 1'b1; d_addr = 32'h40; d_trd = 3'd2;
    tick();
    clear_in();
    chk("t2_replay_data", d_rd_data, 32'hC0DE_0010);
    chk1("t2_replay_miss", d_miss, 1'b0);

    // Simultaneous I and D misses: data fill first, fetch waits.
    lat = 2;
    i_rd = 1'b1; i_addr = 32'h30; d_rd = 1'b1; d_addr = 32'h50;
    tick();
    d_rd = 1'b0; d_addr = 32'h0;
    chk1("arb_i_miss", i_miss, 1'b1);
    chk1("arb_d_miss", d_miss, 1'b1);
    chk("arb_addr", mem_addr, 32'h50);
    chk1("arb_we", mem_we, 1'b0);
    n = 0;
    while (mem_ack !== 1'b1 && n < 100) begin
      tick();
      chk1("arb_i_replay_miss", i_miss, 1'b1);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL arb_ack_timeout: got no ack expected ack within 100 cycles");
    end
    tick();
    chk1("arb_ackcycle_i_miss", i_miss, 1'b1);
    chk1("arb_ackcycle_no_req", mem_req, 1'b0);
    tick();
    clear_in();
    chk1("arb_i_start_miss", i_miss, 1'b1);
    chk1("arb_i_start_req", mem_req, 1'b1);
    chk("arb_i_start_addr", mem_addr, 32'h30);
    wait_done("arb_i", 32'h30, 1'b0);
    i_rd = 1'b1; i_addr = 32'h30; d_rd = 1'b1; d_addr = 32'h50;
    tick();
    clear_in();
    chk("arb_i_hit", i_rd_data, 32'hC0DE_000C);
    chk("arb_d_hit", d_rd_data, 32'hC0DE_0014);
    chk1("arb_d_hit_miss", d_miss, 1'b0);

    // Store updates the I buffer and writes through.
    lat = 1;
    i_rd = 1'b1; i_addr = 32'h20;
    tick();
    clear_in();
    chk1("st_fill_miss", i_miss, 1'b1);
    wait_done("st_fill", 32'h20, 1'b0);
    i_rd = 1'b1; i_addr = 32'h20;
    tick();
    clear_in();
    chk("st_pre_hit", i_rd_data, 32'h0000_AAAA);
    wc0 = wr_cnt;
    d_wr = 1'b1; d_addr = 32'h20; d_wr_data = 32'h0000_5555;
    tick();
    clear_in();
    chk1("st_d_miss", d_miss, 1'b0);
    chk1("st_d_seg", d_segfault, 1'b0);
    chk1("st_req", mem_req, 1'b1);
    chk1("st_we", mem_we, 1'b1);
    chk("st_wdata", mem_wdata, 32'h0000_5555);
    chk("st_addr", mem_addr, 32'h20);
    i_rd = 1'b1; i_addr = 32'h20;
    tick();
    clear_in();
    chk("st_post_hit", i_rd_data, 32'h0000_5555);
    chk1("st_post_miss", i_miss, 1'b0);
    wait_done("st", 32'h20, 1'b1);
    chk("st_wr_cnt", 32'(wr_cnt), 32'(wc0 + 1));
    chk("st_mem", mem[8], 32'h0000_5555);

    // Store while an I fill is outstanding is refused.
    lat = 3;
    i_rd = 1'b1; i_addr = 32'h60;
    tick();
    clear_in();
    chk1("busy_fill_miss", i_miss, 1'b1);
    wc0 = wr_cnt;
    d_wr = 1'b1; d_addr = 32'h60; d_wr_data = 32'h1234;
    tick();
    clear_in();
    chk1("busy_st_miss", d_miss, 1'b1);
    chk1("busy_st_we", mem_we, 1'b0);
    wait_done("busy", 32'h60, 1'b0);
    chk("busy_wr_cnt", 32'(wr_cnt), 32'(wc0));

    // Reset during a D fill drops the request at once and empties buffers.
    d_rd = 1'b1; d_addr = 32'h70;
    tick();
    clear_in();
    chk1("rst_mid_miss", d_miss, 1'b1);
    chk1("rst_mid_req", mem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_req_drop", mem_req, 1'b0);
    chk1("rst_mid_d_miss", d_miss, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    lat = 1;
    i_rd = 1'b1; i_addr = 32'h30; d_rd = 1'b1; d_addr = 32'h50;
    tick();
    clear_in();
    chk1("post_rst_i_miss", i_miss, 1'b1);
    chk1("post_rst_d_miss", d_miss, 1'b1);
    chk("post_rst_addr", mem_addr, 32'h50);
    wait_done("post_rst", 32'h50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
